// File: rtl/apb_rr_master.sv
// apb_rr_master
// Shares one APB master port between NUM_REQ local requesters. A round-robin
// arbiter picks the next requester whenever the bus can take a new transfer.
// Each transfer runs through a SETUP cycle and an ACCESS cycle, with no wait
// states. A one-cycle response pulse then returns the read data and the index
// of the requester that owned the transfer.

module apb_rr_master #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,

    // requester side
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,

    // completion side
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_write,
    output logic [DATA_W-1:0]         rsp_rdata,

    // APB side
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         wdata,
    output logic                      write,
    output logic                      sel,
    output logic                      enable,
    input  logic [DATA_W-1:0]         rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // registered state
    state_t            state_q,     state_d;
    logic [ID_W-1:0]   last_q,      last_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              write_q,     write_d;
    logic              sel_q,       sel_d;
    logic              enable_q,    enable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    // unpacked views of the requester payload buses
    logic [ADDR_W-1:0] slot_addr  [NUM_REQ];
    logic [DATA_W-1:0] slot_wdata [NUM_REQ];

    // arbitration results
    logic              arb_en;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;

    // The owner of the transfer on the bus is always the last granted
    // requester, because the pointer moves exactly at each acceptance.
    logic [ID_W-1:0]   owner;
    assign owner = last_q;

    // A new request can be taken whenever the bus is not in SETUP: in IDLE,
    // or in ACCESS, so that back-to-back transfers are possible.
    assign arb_en = (state_q == ST_IDLE) || (state_q == ST_ACCESS);
    assign accept = arb_en && grant_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign slot_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign slot_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign req_ready[gi]  = accept && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Round-robin search. It starts at last+1 and wraps. Scanning from the
    // farthest candidate down to the nearest lets the nearest valid
    // requester win.
    always_comb begin
        int          cand;
        logic [ID_W-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[ID_W-1:0];
            if (req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Next-state, bus and response computation.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // The transfer completes at the end of this cycle. Read
                // data is captured now and reported on the next cycle.
                rsp_valid_d = 1'b1;
                rsp_id_d    = owner;
                rsp_write_d = write_q;
                rsp_rdata_d = write_q ? '0 : rdata;
                state_d     = accept ? ST_SETUP : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Latch the granted payload. In IDLE without a grant the previous
        // values are held on the bus.
        if (accept) begin
            last_d  = grant_idx;
            addr_d  = slot_addr[grant_idx];
            wdata_d = slot_wdata[grant_idx];
            write_d = req_write[grant_idx];
        end

        // sel and enable are registered and follow the next state. This
        // keeps sel high across ACCESS->SETUP and drops only enable.
        sel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        enable_d = (state_d == ST_ACCESS);
    end

    // State register with synchronous reset. A reset during a transfer
    // aborts it silently: no response pulse, and the bus is released.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign write     = write_q;
    assign sel       = sel_q;
    assign enable    = enable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master
// Directed bench for apb_rr_master. A transaction-level model checks every
// output on every cycle. The model keeps the acceptance cycle of the latest
// transfer, and the bus phase and response timing follow from that cycle.
// Directed tests add literal expectations on grant order, latency and data.

module tb_apb_rr_master;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = $clog2(N);

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic            rsp_write;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic            write;
    logic            sel;
    logic            enable;
    logic [DW-1:0]   rdata = 32'hDEADBEEF;

    apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .addr(addr), .wdata(wdata), .write(write), .sel(sel), .enable(enable),
        .rdata(rdata)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // logs filled by the monitor from the actual DUT outputs
    int          grant_log [$];
    int          grant_cyc [$];
    int          rsp_id_log [$];
    int          rsp_cyc [$];
    logic        rsp_wr_log [$];
    logic [31:0] rsp_rd_log [$];

    logic [N-1:0] grant_seen = '0;
    logic [N-1:0] persist    = '0;
    bit           rdata_fixed = 1'b1;
    int           cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // model state
    int          m_last;
    bit          m_busy;
    int          m_t;
    int          m_id;
    logic [31:0] m_addr, m_wdata;
    logic        m_wr;
    bit          m_rsp_pend;
    int          m_rsp_cyc;
    int          m_rsp_id;
    logic        m_rsp_wr;
    logic [31:0] m_rsp_rd;

    task automatic model_reset();
        m_last = N - 1; m_busy = 0; m_t = 0; m_id = 0;
        m_addr = '0; m_wdata = '0; m_wr = 1'b0;
        m_rsp_pend = 0; m_rsp_cyc = 0; m_rsp_id = 0; m_rsp_wr = 1'b0; m_rsp_rd = '0;
    endtask

    // Monitor and model: sample outputs at negedge, compare, then advance.
    initial begin
        bit in_setup, in_access, exp_rv;
        int g, idx;
        logic [N-1:0] exp_ready;
        model_reset();
        @(posedge clock);
        forever begin
            @(negedge clock);
            cyc++;
            in_setup  = m_busy && (cyc == m_t + 1);
            in_access = m_busy && (cyc == m_t + 2);
            g = -1;
            if (!in_setup) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", req_ready, exp_ready);
            chk("sel", sel, in_setup || in_access);
            chk("enable", enable, in_access);
            chk("addr", addr, m_addr);
            chk("wdata", wdata, m_wdata);
            chk("write", write, m_wr);
            exp_rv = m_rsp_pend && (cyc == m_rsp_cyc);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rsp_id", rsp_id, m_rsp_id);
                chk("rsp_write", rsp_write, m_rsp_wr);
                chk("rsp_rdata", rsp_rdata, m_rsp_rd);
            end
            if (rsp_valid === 1'b1) begin
                rsp_id_log.push_back(int'(rsp_id));
                rsp_wr_log.push_back(rsp_write);
                rsp_rd_log.push_back(rsp_rdata);
                rsp_cyc.push_back(cyc);
                $display("rsp  cyc=%0d id=%0d write=%0b rdata=%08h", cyc, rsp_id, rsp_write, rsp_rdata);
            end
            grant_seen = req_ready;
            if (reset) begin
                model_reset();
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i] === 1'b1) begin
                        grant_log.push_back(i);
                        grant_cyc.push_back(cyc);
                        $display("req  cyc=%0d id=%0d write=%0b addr=%08h wdata=%08h",
                                 cyc, i, req_write[i], req_addr[i*AW +: AW], req_wdata[i*DW +: DW]);
                    end
                end
                if (in_access) begin
                    m_rsp_pend = 1; m_rsp_cyc = cyc + 1; m_rsp_id = m_id;
                    m_rsp_wr = m_wr; m_rsp_rd = m_wr ? 32'h0 : rdata;
                end
                if (g >= 0) begin
                    m_busy = 1; m_t = cyc; m_id = g; m_last = g;
                    m_addr = req_addr[g*AW +: AW];
                    m_wdata = req_wdata[g*DW +: DW];
                    m_wr = req_write[g];
                end
            end
        end
    end

    // One clock step. Granted requesters drop valid unless marked persistent,
    // and rdata changes every cycle unless it is pinned.
    task automatic step();
        @(posedge clock);
        #1;
        req_valid = req_valid & ~(grant_seen & ~persist);
        if (!rdata_fixed) rdata = $urandom;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_write[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int c = 0;
        while (rsp_id_log.size() < n && c < budget) begin
            step();
            c++;
        end
        if (rsp_id_log.size() < n) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout got=%0d responses expected=%0d", rsp_id_log.size(), n);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        int nr, ng;
        repeat (3) step();
        reset = 1'b0;
        // reset state literals
        chk("rst_sel", sel, 0);
        chk("rst_enable", enable, 0);
        chk("rst_addr", addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);

        // single read from requester 0
        rdata_fixed = 1'b1;
        rdata = 32'hDEADBEEF;
        set_req(0, 1'b0, 32'h100, 32'h0);
        wait_rsp(1, 12);
        if (rsp_id_log.size() >= 1 && grant_log.size() >= 1) begin
            chk("read_grant", grant_log[0], 0);
            chk("read_id", rsp_id_log[0], 0);
            chk("read_write", rsp_wr_log[0], 0);
            chk("read_rdata", rsp_rd_log[0], 32'hDEADBEEF);
            chk("read_latency", rsp_cyc[0] - grant_cyc[0], 3);
        end
        rdata_fixed = 1'b0;

        // single write from requester 2
        set_req(2, 1'b1, 32'h20, 32'h12345678);
        wait_rsp(2, 12);
        if (rsp_id_log.size() >= 2) begin
            chk("write_id", rsp_id_log[1], 2);
            chk("write_dir", rsp_wr_log[1], 1);
            chk("write_rdata", rsp_rd_log[1], 0);
        end

        // fairness after skip: serve 1, then 3 and 0 together
        set_req(1, 1'b0, 32'h30, 32'h0);
        wait_rsp(3, 12);
        ng = grant_log.size();
        set_req(3, 1'b0, 32'h3C, 32'h0);
        set_req(0, 1'b1, 32'h0C, 32'hA5A5A5A5);
        wait_rsp(5, 16);
        if (grant_log.size() >= ng + 2) begin
            chk("skip_first", grant_log[ng], 3);
            chk("skip_second", grant_log[ng+1], 0);
        end

        // idle hold after a transfer to 0x44
        set_req(1, 1'b1, 32'h44, 32'h0BADF00D);
        wait_rsp(6, 12);
        repeat (10) step();
        chk("idle_addr", addr, 32'h44);
        chk("idle_sel", sel, 0);
        chk("idle_ready", req_ready, 0);

        // reset during ACCESS of a requester-1 read
        nr = rsp_id_log.size();
        set_req(1, 1'b0, 32'h50, 32'h0);
        begin
            int c = 0;
            while (enable !== 1'b1 && c < 10) begin
                step();
                c++;
            end
            chk("reach_access", enable, 1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_sel", sel, 0);
        chk("abort_enable", enable, 0);
        chk("abort_rsp", rsp_valid, 0);
        repeat (2) step();
        chk("abort_no_rsp", rsp_id_log.size(), nr);
        ng = grant_log.size();
        set_req(1, 1'b0, 32'h54, 32'h0);
        set_req(0, 1'b0, 32'h58, 32'h0);
        wait_rsp(nr + 2, 16);
        if (grant_log.size() >= ng + 2) begin
            chk("post_reset_first", grant_log[ng], 0);
            chk("post_reset_second", grant_log[ng+1], 1);
        end

        // continuous round-robin from reset
        do_reset(2);
        ng = grant_log.size();
        persist = '1;
        for (int i = 0; i < N; i++) set_req(i, i[0], 32'h200 + i*4, 32'h1000 + i);
        begin
            int c = 0;
            while (grant_log.size() < ng + 6 && c < 30) begin
                step();
                c++;
            end
        end
        persist = '0;
        req_valid = '0;
        if (grant_log.size() >= ng + 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("rr_order", grant_log[ng+k], k % N);
                if (k > 0) chk("rr_spacing", grant_cyc[ng+k] - grant_cyc[ng+k-1], 2);
            end
        end else begin
            chk("rr_grants", grant_log.size() - ng, 6);
        end
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
